fc_wr_ctrl: RTL
===============

// Module: fc_wr_ctrl
// PURPOSE
//   Downstream stage of the fully-connected layer. Captures the layer's result matrix on
//   result_valid and writes it to the output memory one 32-bit word per accepted beat,
//   in row-major order (batch row, then column), starting at a sampled base address.
//   Reports completion and flags result_valid pulses that arrive while it is busy.
// PARAMETERS
//   batch_size  1   rows of result matrix (matches FC batch_size)
//   bias_size   2   columns of result matrix (matches FC bias_size)
//   addr_width  16  width of memory word address
// PORTS
//   clk           in   1               single clock, rising edge
//   rst_n         in   1               asynchronous, active-low reset
//   result        in   32 [batch_size][bias_size]  FC result matrix
//   result_valid  in   1               1-cycle pulse: result is valid this cycle
//   base_addr     in   addr_width      first write address, sampled with result
//   mem_wr_ready  in   1               memory accepts the current beat
//   mem_wr_en     out  1               write beat valid
//   mem_wr_addr   out  addr_width      write word address
//   mem_wr_data   out  32              write data
//   busy          out  1               capture held, writes outstanding
//   done          out  1               1-cycle pulse after last beat accepted
//   overrun       out  1               1-cycle pulse: result_valid dropped while busy
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE; mem_wr_en, busy, done, overrun = 0;
//     mem_wr_addr, mem_wr_data, element index = 0; captured buffer contents don't-care.
//   - States: IDLE, WRITE, DONE. N = batch_size*bias_size.
//   - IDLE/DONE: result_valid=1 -> capture all N words and base_addr, index<=0, go WRITE.
//     Otherwise IDLE stays IDLE; DONE returns to IDLE after exactly 1 cycle.
//   - WRITE: mem_wr_en=1, mem_wr_data=buf[idx/bias_size][idx%bias_size],
//     mem_wr_addr=base+idx (mod 2^addr_width, wrap silently). Beat accepted when
//     mem_wr_en & mem_wr_ready; then idx++. Addr/data stable while ready=0.
//     Acceptance of beat idx=N-1 -> DONE.
//   - done=1 exactly in DONE cycle. busy=1 in WRITE and DONE.
//   - Latency (ready tied 1): result_valid at edge T -> beats at cycles T+1..T+N,
//     done at T+N+1; next capture allowed in the done cycle (back-to-back, no bubble).
//   - result_valid in WRITE: new data ignored, overrun=1 next cycle, writes continue
//     unaffected with captured data.
//   - rst_n asserted mid-WRITE: outstanding beats abandoned, no done pulse.
//   - Outputs registered; no combinational path from result_valid to mem_wr_* .
// CONFIGURATION
//   FC_WR_RELU_EN defined: ReLU applied at capture -- any word with bit31=1 stored as
//     32'h0, others unchanged (valid for two's-complement and IEEE-754 data; -0.0 -> +0).
//   FC_WR_RELU_EN undefined: words stored and written bit-exact.
// TESTING
//   1. batch 1, bias 2, ready=1, result={32'h5,32'h7}, base=16'h0100, valid at T
//      -> beats (0100,5),(0101,7) at T+1,T+2; done at T+3; busy T+1..T+3.
//   2. ready low 3 cycles on beat 0 -> addr/data held, mem_wr_en=1, no extra beats,
//      done delayed 3 cycles.
//   3. base=16'hFFFF, N=2 -> addresses FFFF then 0000.
//   4. valid again during WRITE -> overrun 1-cycle pulse; written data = first capture;
//      valid in DONE cycle -> accepted, next beat follows with no gap.
//   5. rst_n low after beat 0 -> all outputs 0 asynchronously; after release, IDLE,
//      no done; new valid writes cleanly from idx 0.
//   6. result={32'hFFFFFFF0,32'h3}: FC_WR_RELU_EN -> data 0,3; undefined -> FFFFFFF0,3.

Source files
------------

// File: rtl/fc_wr_ctrl.sv
// fc_wr_ctrl: captures the FC result matrix and streams it row-major to memory; FC_WR_RELU_EN enables ReLU at capture
module fc_wr_ctrl #(
  parameter int batch_size = 1,
  parameter int bias_size  = 2,
  parameter int addr_width = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           result [batch_size][bias_size],
  input  logic                  result_valid,
  input  logic [addr_width-1:0] base_addr,
  input  logic                  mem_wr_ready,
  output logic                  mem_wr_en,
  output logic [addr_width-1:0] mem_wr_addr,
  output logic [31:0]           mem_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);
  localparam int N  = batch_size * bias_size;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t                state, state_nx;
  logic [IW-1:0]         idx;
  logic [addr_width-1:0] base;
  logic [31:0]           cap [N];
  logic                  take, beat, last;
  function automatic logic [31:0] relu(input logic [31:0] w);
`ifdef FC_WR_RELU_EN
    return w[31] ? 32'h0 : w;
`else
    return w;
`endif
  endfunction
  assign take = result_valid && state != WRITE;
  assign beat = state == WRITE && mem_wr_ready;
  assign last = idx == IW'(N - 1);
  // next state: a capture always starts a write; DONE lasts exactly one cycle
  always_comb begin
    state_nx = take ? WRITE : state == WRITE ? (beat && last ? DONE : WRITE) : IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  // beat index, sampled base address and overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      base    <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= result_valid && state == WRITE;
      if (take) begin
        idx  <= '0;
        base <= base_addr;
      end else if (beat) begin
        idx <= last ? '0 : idx + 1'b1;
      end
    end
  end
  // capture buffer, flattened row-major; contents are don't-care until the first capture
  always_ff @(posedge clk) begin
    if (take)
      for (int r = 0; r < batch_size; r++)
        for (int c = 0; c < bias_size; c++)
          cap[r * bias_size + c] <= relu(result[r][c]);
  end
  assign mem_wr_en   = state == WRITE;
  assign busy        = state != IDLE;
  assign done        = state == DONE;
  assign mem_wr_addr = mem_wr_en ? base + addr_width'(idx) : '0;
  assign mem_wr_data = mem_wr_en ? cap[idx] : '0;
endmodule
